// File: rtl/wb_epb_bridge.sv
// Wishbone classic slave to EPB master: each accepted WB cycle becomes one EPB access.
// Define WB_EPB_TIMEOUT_EN to add an assert-phase timeout that answers with wbs_err_o.
module wb_epb_bridge #(
    parameter int WB_ADDR_WIDTH  = 32,
    parameter int SETUP_CYCLES   = 1,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                     wb_clk_i,
    input  logic                     wb_rst_i,
    input  logic                     wbs_cyc_i,
    input  logic                     wbs_stb_i,
    input  logic                     wbs_we_i,
    input  logic [3:0]               wbs_sel_i,
    input  logic [WB_ADDR_WIDTH-1:0] wbs_adr_i,
    input  logic [31:0]              wbs_dat_i,
    output logic [31:0]              wbs_dat_o,
    output logic                     wbs_ack_o,
    output logic                     wbs_err_o,
    output logic                     epb_cs_n,
    output logic                     epb_oe_n,
    output logic                     epb_r_w_n,
    output logic [3:0]               epb_be_n,
    output logic [5:29]              epb_addr,
    output logic [0:31]              epb_data_o,
    input  logic [0:31]              epb_data_i,
    output logic                     epb_data_oe_n,
    input  logic                     epb_rdy
);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_SETUP  = 3'd1;
    localparam logic [2:0] S_ASSERT = 3'd2;
    localparam logic [2:0] S_RESP   = 3'd3;
    localparam logic [2:0] S_TURN   = 3'd4;

    logic [2:0]  state_q, state_d;
    logic [3:0]  setup_cnt_q, setup_cnt_d;
    logic        abort_q, abort_d;
    logic        rd_q, rd_d;
    logic [3:0]  be_n_q, be_n_d;
    logic [24:0] addr_q, addr_d;
    logic [31:0] wdat_q, wdat_d;
    logic [31:0] rdat_q, rdat_d;
    logic        ack_q, ack_d;
    logic        err_q, err_d;
    logic        to_expire;
    logic        drive;
    logic        unused_adr;

    // Only the 25-bit word address reaches the EPB side.
    assign unused_adr = ^wbs_adr_i;

`ifdef WB_EPB_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    logic [TW-1:0] to_cnt_q, to_cnt_d;

    // Held at zero outside ASSERT, so every assert phase starts counting from 0.
    always_comb begin
        to_cnt_d = '0;
        if (state_q == S_ASSERT) to_cnt_d = to_cnt_q + TW'(1);
    end

    assign to_expire = (to_cnt_q == TW'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) to_cnt_q <= '0;
        else          to_cnt_q <= to_cnt_d;
    end
`else
    assign to_expire = 1'b0;
`endif

    always_comb begin
        state_d     = state_q;
        setup_cnt_d = setup_cnt_q;
        abort_d     = abort_q;
        rd_d        = rd_q;
        be_n_d      = be_n_q;
        addr_d      = addr_q;
        wdat_d      = wdat_q;
        rdat_d      = rdat_q;
        ack_d       = 1'b0;
        err_d       = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (wbs_cyc_i && wbs_stb_i) begin
                    state_d     = S_SETUP;
                    setup_cnt_d = '0;
                    abort_d     = 1'b0;
                    rd_d        = ~wbs_we_i;
                    be_n_d      = ~wbs_sel_i;
                    addr_d      = wbs_adr_i[26:2];
                    wdat_d      = wbs_dat_i;
                end
            end
            S_SETUP: begin
                if (!wbs_cyc_i)                                  state_d = S_IDLE;
                else if (setup_cnt_q == 4'(SETUP_CYCLES - 1))    state_d = S_ASSERT;
                else                                             setup_cnt_d = setup_cnt_q + 4'd1;
            end
            S_ASSERT: begin
                // Once the master walks away the access still finishes, silently.
                if (!wbs_cyc_i) abort_d = 1'b1;
                if (epb_rdy) begin
                    state_d = S_RESP;
                    ack_d   = wbs_cyc_i & ~abort_q;
                    if (rd_q) rdat_d = epb_data_i;
                end else if (to_expire) begin
                    state_d = S_RESP;
                    err_d   = wbs_cyc_i & ~abort_q;
                    rdat_d  = '0;
                end
            end
            S_RESP:  state_d = S_TURN;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            state_q     <= S_IDLE;
            setup_cnt_q <= '0;
            abort_q     <= 1'b0;
            rd_q        <= 1'b1;
            be_n_q      <= 4'hF;
            addr_q      <= '0;
            wdat_q      <= '0;
            rdat_q      <= '0;
            ack_q       <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            setup_cnt_q <= setup_cnt_d;
            abort_q     <= abort_d;
            rd_q        <= rd_d;
            be_n_q      <= be_n_d;
            addr_q      <= addr_d;
            wdat_q      <= wdat_d;
            rdat_q      <= rdat_d;
            ack_q       <= ack_d;
            err_q       <= err_d;
        end
    end

    // Strobes decode straight from state so an async reset releases them at once.
    assign drive         = (state_q == S_SETUP) || (state_q == S_ASSERT);
    assign epb_cs_n      = (state_q != S_ASSERT);
    assign epb_oe_n      = ~((state_q == S_ASSERT) && rd_q);
    assign epb_data_oe_n = ~((state_q == S_ASSERT) && !rd_q);
    assign epb_r_w_n     = drive ? rd_q   : 1'b1;
    assign epb_be_n      = drive ? be_n_q : 4'hF;
    assign epb_addr      = addr_q;
    assign epb_data_o    = wdat_q;
    assign wbs_dat_o     = rdat_q;
    assign wbs_ack_o     = ack_q;
    assign wbs_err_o     = err_q;

endmodule

// File: tb/tb_wb_epb_bridge.sv
// Scoreboard bench for wb_epb_bridge: driver pushes expected WB responses and EPB
// accesses, one negedge checker pops and compares them against what the DUT shows.
`timescale 1ns/1ps
module tb_wb_epb_bridge;

    localparam int S  = 1;
    localparam int TO = 16;

    logic        wb_clk_i = 1'b0;
    logic        wb_rst_i = 1'b1;
    logic        wbs_cyc_i = 1'b0, wbs_stb_i = 1'b0, wbs_we_i = 1'b0;
    logic [3:0]  wbs_sel_i = '0;
    logic [31:0] wbs_adr_i = '0, wbs_dat_i = '0;
    logic [31:0] wbs_dat_o;
    logic        wbs_ack_o, wbs_err_o;
    logic        epb_cs_n, epb_oe_n, epb_r_w_n, epb_data_oe_n;
    logic [3:0]  epb_be_n;
    logic [5:29] epb_addr;
    logic [0:31] epb_data_o;
    logic [0:31] epb_data_i;
    logic        epb_rdy = 1'b0;

    wb_epb_bridge #(.WB_ADDR_WIDTH(32), .SETUP_CYCLES(S), .TIMEOUT_CYCLES(TO)) dut (
        .wb_clk_i(wb_clk_i), .wb_rst_i(wb_rst_i),
        .wbs_cyc_i(wbs_cyc_i), .wbs_stb_i(wbs_stb_i), .wbs_we_i(wbs_we_i),
        .wbs_sel_i(wbs_sel_i), .wbs_adr_i(wbs_adr_i), .wbs_dat_i(wbs_dat_i),
        .wbs_dat_o(wbs_dat_o), .wbs_ack_o(wbs_ack_o), .wbs_err_o(wbs_err_o),
        .epb_cs_n(epb_cs_n), .epb_oe_n(epb_oe_n), .epb_r_w_n(epb_r_w_n),
        .epb_be_n(epb_be_n), .epb_addr(epb_addr), .epb_data_o(epb_data_o),
        .epb_data_i(epb_data_i), .epb_data_oe_n(epb_data_oe_n), .epb_rdy(epb_rdy)
    );

    always #5 wb_clk_i = ~wb_clk_i;

    longint cyc_n = 0;
    always @(posedge wb_clk_i) cyc_n++;

    typedef struct { bit is_err; bit chk_dat; logic [31:0] dat; longint cyc; } resp_t;
    typedef struct { logic [24:0] addr; logic [3:0] be_n; logic r_w_n; logic [31:0] wdat; int len; } epb_t;
    resp_t resp_q[$];
    epb_t  epb_q[$];

    int vectors = 0, miscompares = 0;

    // EPB target: raises rdy in its tgt_dly-th assert cycle (0 = never), random noise otherwise.
    int          tgt_dly = 1, tgt_n = 0;
    bit          tgt_stuck = 1'b0;
    logic [31:0] tgt_rdata = '0;
    assign epb_data_i = tgt_rdata;

    always @(negedge wb_clk_i) begin
        if (!epb_cs_n) begin
            tgt_n   = tgt_n + 1;
            epb_rdy = tgt_stuck || (tgt_dly != 0 && tgt_n == tgt_dly);
        end else begin
            tgt_n   = 0;
            epb_rdy = tgt_stuck || ($urandom_range(0, 3) == 0);
        end
    end

    int         snap_seq = 0, noresp_seq = 0, done_seq = 0;
    logic [6:0] snap_val = '0;

    task automatic chk(input bit ok, input string nm, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (!ok) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc_n);
        end
    endtask

    // Single checker process: WB responses, EPB accesses, reset values.
    int    snap_seen = 0, noresp_seen = 0, done_seen = 0, asr_len = 0;
    bit    in_asr = 1'b0, have_cur = 1'b0;
    epb_t  cur;
    resp_t r;
    always @(negedge wb_clk_i) begin
        if (wb_rst_i) begin
            chk(epb_cs_n && epb_oe_n && epb_r_w_n && epb_be_n == 4'hF && epb_data_oe_n,
                "rst_strobes", {epb_cs_n, epb_oe_n, epb_r_w_n, epb_be_n, epb_data_oe_n}, 8'hFF);
            chk(epb_addr == 25'd0 && epb_data_o == 32'd0 && wbs_dat_o == 32'd0,
                "rst_data", {epb_addr, wbs_dat_o}, 0);
            chk(!wbs_ack_o && !wbs_err_o, "rst_resp", {wbs_ack_o, wbs_err_o}, 0);
            in_asr = 1'b0;
        end else begin
            if (wbs_ack_o || wbs_err_o) begin
                chk(resp_q.size() > 0, "resp_expected", resp_q.size(), 1);
                if (resp_q.size() > 0) begin
                    r = resp_q.pop_front();
                    chk(wbs_ack_o == !r.is_err && wbs_err_o == r.is_err, "resp_kind",
                        {wbs_ack_o, wbs_err_o}, {!r.is_err, r.is_err});
                    chk(cyc_n == r.cyc, "resp_cycle", cyc_n, r.cyc);
                    if (r.chk_dat) chk(wbs_dat_o == r.dat, "rdata", wbs_dat_o, r.dat);
                end
            end
            if (!epb_cs_n) begin
                if (!in_asr) begin
                    in_asr  = 1'b1;
                    asr_len = 0;
                    chk(epb_q.size() > 0, "cs_expected", epb_q.size(), 1);
                    have_cur = (epb_q.size() > 0);
                    if (have_cur) begin
                        cur = epb_q.pop_front();
                        chk(epb_addr == cur.addr, "epb_addr", epb_addr, cur.addr);
                        chk(epb_be_n == cur.be_n, "epb_be_n", epb_be_n, cur.be_n);
                        chk(epb_r_w_n == cur.r_w_n, "epb_r_w_n", epb_r_w_n, cur.r_w_n);
                        if (!cur.r_w_n) chk(epb_data_o == cur.wdat, "epb_wdata", epb_data_o, cur.wdat);
                    end
                end
                asr_len++;
                if (have_cur)
                    chk({epb_oe_n, epb_data_oe_n} == (cur.r_w_n ? 2'b01 : 2'b10), "assert_strobes",
                        {epb_oe_n, epb_data_oe_n}, cur.r_w_n ? 2'b01 : 2'b10);
            end else begin
                chk(epb_oe_n && epb_data_oe_n, "idle_strobes", {epb_oe_n, epb_data_oe_n}, 2'b11);
                if (in_asr) begin
                    in_asr = 1'b0;
                    if (have_cur) chk(asr_len == cur.len, "assert_len", asr_len, cur.len);
                end
            end
        end
        if (snap_seq != snap_seen) begin
            snap_seen = snap_seq;
            chk(snap_val == 7'h7F, "rst_async", snap_val, 7'h7F);
        end
        if (noresp_seq != noresp_seen) begin
            noresp_seen = noresp_seq;
            chk(resp_q.size() == 0, "resp_pending", resp_q.size(), 0);
            resp_q.delete();
        end
        if (done_seq != done_seen) begin
            done_seen = done_seq;
            chk(resp_q.size() == 0, "resp_left", resp_q.size(), 0);
            chk(epb_q.size() == 0, "epb_left", epb_q.size(), 0);
        end
    end

    task automatic wb_release();
        wbs_cyc_i = 1'b0;
        wbs_stb_i = 1'b0;
    endtask

    // mode: 0 normal, 1 drop cyc in SETUP, 2 drop cyc in ASSERT, 3 reset in ASSERT
    task automatic xfer(input bit we, input logic [31:0] adr, input logic [31:0] dat,
                        input logic [3:0] sel, input int dly, input logic [31:0] rdat, input int mode);
        int     len;
        bit     to, got;
        longint a;
        resp_t  rr;
        epb_t   e;
        @(negedge wb_clk_i);
        len = tgt_stuck ? 1 : dly;
        to  = 1'b0;
`ifdef WB_EPB_TIMEOUT_EN
        if (len == 0 || len > TO) begin
            to  = 1'b1;
            len = TO;
        end
`endif
        a         = cyc_n + 1;
        tgt_dly   = dly;
        tgt_rdata = rdat;
        e.addr = adr[26:2]; e.be_n = ~sel; e.r_w_n = ~we; e.wdat = dat; e.len = len;
        rr.is_err = to; rr.chk_dat = to || !we; rr.dat = to ? 32'd0 : rdat; rr.cyc = a + S + len;
        if (mode != 1) epb_q.push_back(e);
        if (mode == 0) resp_q.push_back(rr);
        wbs_cyc_i = 1'b1; wbs_stb_i = 1'b1; wbs_we_i = we;
        wbs_sel_i = sel;  wbs_adr_i = adr;  wbs_dat_i = dat;
        case (mode)
            0: begin
                got = 1'b0;
                for (int i = 0; i < 200 && !got; i++) begin
                    @(negedge wb_clk_i);
                    got = wbs_ack_o || wbs_err_o;
                end
                if (!got) noresp_seq++;
                wb_release();
                repeat (2) @(negedge wb_clk_i);
            end
            1: begin
                @(negedge wb_clk_i);
                wb_release();
                repeat (3) @(negedge wb_clk_i);
            end
            2: begin
                repeat (S + 1) @(negedge wb_clk_i);
                wb_release();
                for (int i = 0; i < 100 && !epb_cs_n; i++) @(negedge wb_clk_i);
                repeat (3) @(negedge wb_clk_i);
            end
            default: begin
                repeat (S + 1) @(negedge wb_clk_i);
                #2 wb_rst_i = 1'b1;
                wb_release();
                #1 snap_val = {epb_cs_n, epb_oe_n, epb_be_n, epb_data_oe_n};
                snap_seq++;
                @(negedge wb_clk_i);
                #2 wb_rst_i = 1'b0;
                repeat (2) @(negedge wb_clk_i);
            end
        endcase
    endtask

    // Two reads with cyc/stb held: accepts SETUP_CYCLES+4 apart.
    task automatic b2b(input logic [31:0] adr, input logic [31:0] d1, input logic [31:0] d2);
        longint a;
        resp_t  rr;
        epb_t   e;
        int     acks;
        acks = 0;
        @(negedge wb_clk_i);
        a         = cyc_n + 1;
        tgt_dly   = 1;
        tgt_rdata = d1;
        e.addr = adr[26:2]; e.be_n = 4'h0; e.r_w_n = 1'b1; e.wdat = '0; e.len = 1;
        epb_q.push_back(e);
        epb_q.push_back(e);
        rr.is_err = 1'b0; rr.chk_dat = 1'b1; rr.dat = d1; rr.cyc = a + S + 1;
        resp_q.push_back(rr);
        rr.dat = d2; rr.cyc = a + (S + 4) + S + 1;
        resp_q.push_back(rr);
        wbs_cyc_i = 1'b1; wbs_stb_i = 1'b1; wbs_we_i = 1'b0;
        wbs_sel_i = 4'hF; wbs_adr_i = adr;  wbs_dat_i = '0;
        for (int i = 0; i < 100 && acks < 2; i++) begin
            @(negedge wb_clk_i);
            if (wbs_ack_o || wbs_err_o) begin
                acks++;
                tgt_rdata = d2;
            end
        end
        if (acks < 2) noresp_seq++;
        wb_release();
        repeat (2) @(negedge wb_clk_i);
    endtask

    initial begin
        int          m, d;
        logic [31:0] ra, rd, rv;
        repeat (3) @(negedge wb_clk_i);
        #2 wb_rst_i = 1'b0;

        xfer(1'b1, 32'h0000_0010, 32'hA5A5_1234, 4'b0011, 1, 32'h0, 0);
        xfer(1'b0, 32'h0000_0100, 32'h0, 4'hF, 5, 32'hDEAD_BEEF, 0);
`ifdef WB_EPB_TIMEOUT_EN
        xfer(1'b0, 32'h0000_0200, 32'h0, 4'hF, 0, 32'h1234_5678, 0);
        xfer(1'b0, 32'h0000_0204, 32'h0, 4'hF, TO, 32'h0BAD_CAFE, 0);
        xfer(1'b1, 32'h0000_0208, 32'h5555_AAAA, 4'hC, TO + 1, 32'h0, 0);
`else
        xfer(1'b0, 32'h0000_0200, 32'h0, 4'hF, 40, 32'h1234_5678, 0);
`endif
        xfer(1'b1, 32'h0000_0300, 32'h1111_2222, 4'hF, 3, 32'h0, 1);
        xfer(1'b0, 32'h0000_0304, 32'h0, 4'h3, 4, 32'h7777_8888, 2);
        xfer(1'b1, 32'h0000_0400, 32'h1122_3344, 4'hF, 8, 32'h0, 3);
        xfer(1'b0, 32'h0000_0404, 32'h0, 4'hF, 2, 32'hCAFE_F00D, 0);
        b2b(32'h0000_0500, 32'h0123_4567, 32'h89AB_CDEF);
        tgt_stuck = 1'b1;
        xfer(1'b0, 32'h0000_0600, 32'h0, 4'hF, 7, 32'h5A5A_A5A5, 0);
        tgt_stuck = 1'b0;

        for (int k = 0; k < 30; k++) begin
            m = 0;
            if ($urandom_range(0, 9) == 0) m = 1;
            else if ($urandom_range(0, 9) == 0) m = 2;
            d = $urandom_range(1, 12);
`ifdef WB_EPB_TIMEOUT_EN
            if ($urandom_range(0, 7) == 0) d = 0;
`endif
            ra = $urandom;
            rd = $urandom;
            rv = $urandom;
            xfer(1'($urandom_range(0, 1)), ra, rd, 4'($urandom_range(0, 15)), d, rv, m);
        end

        repeat (4) @(negedge wb_clk_i);
        done_seq++;
        repeat (2) @(negedge wb_clk_i);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: run did not complete, %0d vectors applied", vectors);
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/wb_epb_bridge.md
# wb_epb_bridge

Wishbone slave to EPB master bridge: accepts single Wishbone classic cycles from the FPGA-side interconnect and replays each as one EPB bus transaction (chip-select, output-enable, read/write, byte enables, address, data) towards an external EPB target, completing the Wishbone cycle when the target raises `epb_rdy`. It is the initiating end of the EPB link whose responding end our EPB-to-WB bridge implements, and lets on-chip masters reach EPB-attached devices.

## Interface
- `WB_ADDR_WIDTH`, 32, Wishbone byte-address width; must be ≥27.
- `SETUP_CYCLES`, 1, cycles address/control are held stable with `epb_cs_n` high before assertion; range 1–15.
- `TIMEOUT_CYCLES`, 1024, assert-phase cycles without `epb_rdy` before error; used only with `WB_EPB_TIMEOUT_EN`.

- `wb_clk_i` in 1, single clock; EPB bus is synchronous to it.
- `wb_rst_i` in 1, reset: asynchronous, active-high.
- `wbs_cyc_i` in 1, Wishbone cycle.
- `wbs_stb_i` in 1, Wishbone strobe.
- `wbs_we_i` in 1, 1 = write.
- `wbs_sel_i` in 4, byte selects.
- `wbs_adr_i` in WB_ADDR_WIDTH, byte address.
- `wbs_dat_i` in 32, write data.
- `wbs_dat_o` out 32, read data, registered.
- `wbs_ack_o` out 1, one-cycle completion pulse.
- `wbs_err_o` out 1, one-cycle timeout-error pulse.
- `epb_cs_n` out 1, chip select, active-low.
- `epb_oe_n` out 1, read output enable, active-low.
- `epb_r_w_n` out 1, 1 = read, 0 = write.
- `epb_be_n` out 4, byte enables, active-low.
- `epb_addr` out [5:29], word address.
- `epb_data_o` out [0:31], write data.
- `epb_data_i` in [0:31], read data from target.
- `epb_data_oe_n` out 1, low while the bridge drives write data.
- `epb_rdy` in 1, target ready, active-high.

## Operation
- Reset values: `epb_cs_n`=1, `epb_oe_n`=1, `epb_r_w_n`=1, `epb_be_n`=4'hF, `epb_addr`=0, `epb_data_o`=0, `epb_data_oe_n`=1, `wbs_ack_o`=0, `wbs_err_o`=0, `wbs_dat_o`=0, state IDLE, timeout counter 0.
- Mapping, latched on accept: `epb_addr`=`wbs_adr_i[26:2]`; `epb_be_n`=~`wbs_sel_i`; `epb_r_w_n`=~`wbs_we_i`; `epb_data_o`=`wbs_dat_i` as direct vector assignment, so EPB bit 0 is WB bit 31. On reads, `wbs_dat_o` takes `epb_data_i` the same way.
- IDLE: all EPB strobes inactive. If `wbs_cyc_i & wbs_stb_i`, latch the request and go to SETUP.
- SETUP: drive address, `epb_be_n` and `epb_r_w_n`, with `epb_cs_n`=1. After `SETUP_CYCLES` cycles go to ASSERT. If `wbs_cyc_i` drops, go to IDLE without asserting `epb_cs_n`.
- ASSERT: `epb_cs_n`=0. On a read, `epb_oe_n`=0. On a write, `epb_data_oe_n`=0. When `epb_rdy` is sampled high, capture read data and go to RESP.
- RESP: `epb_cs_n`, `epb_oe_n` and `epb_data_oe_n` return to 1. Pulse `wbs_ack_o` (or `wbs_err_o`) for exactly one cycle, then go to TURN.
- TURN: one bus-turnaround cycle with everything inactive, then IDLE.
- Abort in ASSERT: if `wbs_cyc_i` drops, the EPB access still completes on `epb_rdy` or timeout, but the ack/err pulse is suppressed.
- `epb_rdy` is ignored outside ASSERT; a stuck-high `epb_rdy` never completes a transaction twice.
- `wbs_ack_o` and `wbs_err_o` are never high together.

## Timing
- The request is sampled in IDLE at edge 0, and `epb_cs_n` falls after `SETUP_CYCLES`. With `epb_rdy` high in the first ASSERT cycle, `wbs_ack_o` is high in cycle `SETUP_CYCLES`+2 (cycle 3 at default).
- Minimum back-to-back spacing is `SETUP_CYCLES`+4 cycles between accepts.
- `wbs_dat_o` is valid in the ack cycle and holds until the next read capture.
- Asynchronous reset takes effect immediately in any state: EPB strobes release at once and no ack is emitted.

## Configuration
- `WB_EPB_TIMEOUT_EN` defined: the ASSERT counter starts at 0 on entry. If it reaches `TIMEOUT_CYCLES` without `epb_rdy`, the bridge goes to RESP, pulses `wbs_err_o` instead of `wbs_ack_o`, and writes `wbs_dat_o`=0. An `epb_rdy` arriving in the same cycle as the terminal count wins and produces an ack.
- Undefined: no counter; ASSERT waits indefinitely for `epb_rdy`; `wbs_err_o` is tied to 0.

## Test plan
- Write: adr 0x0000_0010, dat 0xA5A5_1234, sel 4'b0011, `epb_rdy` on the first assert cycle → `epb_addr`=4, `epb_be_n`=4'b1100, `epb_r_w_n`=0, `epb_data_oe_n` low only in ASSERT, ack in cycle 3.
- Read: adr 0x0000_0100, target returns 0xDEAD_BEEF after 5 assert cycles → `epb_oe_n` low for 5 cycles, `wbs_dat_o`=0xDEAD_BEEF with the single-cycle ack.
- Timeout (macro on, `TIMEOUT_CYCLES`=16): `epb_rdy` held low → `wbs_err_o` pulses after 16 assert cycles, `wbs_dat_o`=0, no ack; macro off → no err, waits.
- Abort: `wbs_cyc_i` dropped in SETUP → `epb_cs_n` never falls; dropped in ASSERT → access completes on `epb_rdy`, no ack.
- Reset: `wb_rst_i` asserted mid-ASSERT → `epb_cs_n`=1, `epb_be_n`=4'hF, `epb_data_oe_n`=1 before the next edge; next request after release proceeds normally.
- Back-to-back: two reads with `wbs_stb_i` held → accepts spaced 5 cycles at `SETUP_CYCLES`=1, one ack per access.
